// File: rtl/controller_poller_apb.sv
// APB3 slave polling NUM_CH serial shift-register gamepads over a shared latch/clock pair.
// Frames start on a POLL write or a periodic timer expiry and capture each pad into STATE.
module controller_poller_apb #(
  parameter int NUM_CH       = 2,
  parameter int NBITS        = 8,
  parameter int HALF_DIV     = 300,
  parameter int POLL_DEFAULT = 833333
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              contLATCH,
  output logic              contCLK,
  input  logic [NUM_CH-1:0] contREAD,
  output logic              IRQ
);

  localparam int CNT_W = $clog2(2 * HALF_DIV);
  localparam int BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HALF_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NBITS - 1);

  typedef enum logic [2:0] {IDLE, LATCH, CLKHI, CLKLO, DONE} pollState_e;

  pollState_e fsmReg, fsmNext;
  logic [CNT_W-1:0] cntReg;
  logic [BIT_W-1:0] bitReg;
  logic ctrlEn, ctrlIe, irqReg, latchReg, clkReg;
  logic [23:0] pollPeriod, timerReg;
  logic [NUM_CH-1:0] changedReg, changedNext, diffVec, w1cMask;
  logic [7:0] frameCnt;
  logic [NBITS-1:0] padStateArr [NUM_CH];
  logic wrEn, pollWrite, timerExpire, trigger, phaseLast;
  logic sampleNow, doneNow, busy, latchNext, clkNext, mapped;
  logic [5:0] addrWord, stIdx;
  logic [31:0] rdData;
  logic unusedBits;

  assign wrEn        = PSEL & PENABLE & PWRITE;
  assign addrWord    = PADDR[7:2];
  assign stIdx       = addrWord - 6'd4;
  assign pollWrite   = wrEn && (addrWord == 6'd0) && PWDATA[1];
  assign timerExpire = ctrlEn && (pollPeriod != 24'd0) && (timerReg == 24'd1);
  assign trigger     = pollWrite | timerExpire;
  assign unusedBits  = ^{PADDR[1:0], PWDATA[31:24]};

  always_comb begin
    phaseLast = (fsmReg == LATCH) ? (cntReg == LATCH_LAST) : (cntReg == HALF_LAST);
  end

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) fsmReg <= IDLE;
    else        fsmReg <= fsmNext;
  end

  // Next-state logic; triggers outside IDLE are simply not looked at
  always_comb begin
    fsmNext = fsmReg;
    case (fsmReg)
      IDLE:    if (trigger) fsmNext = LATCH;
      LATCH:   if (phaseLast) fsmNext = (NBITS == 1) ? DONE : CLKHI;
      CLKHI:   if (phaseLast) fsmNext = CLKLO;
      CLKLO:   if (phaseLast) fsmNext = (bitReg == BIT_LAST) ? DONE : CLKHI;
      DONE:    fsmNext = IDLE;
      default: fsmNext = IDLE;
    endcase
  end

  // Output decode; pad strobes come from fsmNext so the registered copies line up with the state
  always_comb begin
    busy      = (fsmReg != IDLE);
    sampleNow = phaseLast && ((fsmReg == LATCH) || (fsmReg == CLKLO));
    doneNow   = (fsmReg == DONE);
    latchNext = (fsmNext == LATCH);
    clkNext   = (fsmNext == CLKHI);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cntReg   <= '0;
      bitReg   <= '0;
      latchReg <= 1'b0;
      clkReg   <= 1'b0;
    end else begin
      latchReg <= latchNext;
      clkReg   <= clkNext;
      if (fsmReg == IDLE || fsmReg == DONE || phaseLast) cntReg <= '0;
      else cntReg <= cntReg + CNT_W'(1);
      if (fsmReg == IDLE) bitReg <= '0;
      else if (sampleNow) bitReg <= bitReg + BIT_W'(1);
    end
  end

  // A DONE set outranks a same-cycle write-1-to-clear
  always_comb begin
    w1cMask     = (wrEn && addrWord == 6'd3) ? PWDATA[NUM_CH-1:0] : '0;
    changedNext = (changedReg & ~w1cMask) | (doneNow ? diffVec : '0);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrlEn     <= 1'b0;
      ctrlIe     <= 1'b0;
      pollPeriod <= 24'(POLL_DEFAULT);
      timerReg   <= 24'(POLL_DEFAULT);
      changedReg <= '0;
      frameCnt   <= 8'd0;
      irqReg     <= 1'b0;
    end else begin
      irqReg     <= ctrlIe & (|changedReg);
      changedReg <= changedNext;
      if (wrEn && addrWord == 6'd0) begin
        ctrlEn <= PWDATA[0];
        ctrlIe <= PWDATA[2];
      end
      if (wrEn && addrWord == 6'd2) begin
        pollPeriod <= PWDATA[23:0];
        timerReg   <= PWDATA[23:0];
      end else if (ctrlEn && pollPeriod != 24'd0) begin
        timerReg <= (timerReg <= 24'd1) ? pollPeriod : timerReg - 24'd1;
      end
      if (doneNow) frameCnt <= frameCnt + 8'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [NBITS-1:0] shiftBits, heldBits;
      always_ff @(posedge PCLK) begin
        if (PRESET) begin
          shiftBits <= '0;
          heldBits  <= '0;
        end else begin
          if (sampleNow) shiftBits[bitReg] <= ~contREAD[gi];
          if (doneNow) heldBits <= shiftBits;
        end
      end
      assign diffVec[gi]     = (shiftBits != heldBits);
      assign padStateArr[gi] = heldBits;
    end
  endgenerate

  always_comb begin
    rdData = '0;
    mapped = 1'b1;
    case (addrWord)
      6'd0: rdData = {29'd0, ctrlIe, 1'b0, ctrlEn};
      6'd1: rdData = {16'd0, frameCnt, 7'd0, busy};
      6'd2: rdData = {8'd0, pollPeriod};
      6'd3: rdData[NUM_CH-1:0] = changedReg;
      default: begin
        mapped = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
          if (stIdx == 6'(i)) begin
            mapped             = 1'b1;
            rdData[NBITS-1:0] = padStateArr[i];
          end
        end
      end
    endcase
  end

  assign PRDATA    = rdData;
  assign PREADY    = 1'b1;
  assign PSLVERR   = PSEL & PENABLE & ~mapped;
  assign contLATCH = latchReg;
  assign contCLK   = clkReg;
  assign IRQ       = irqReg;

endmodule

// File: tb/tb_controller_poller_apb.sv
// Directed bench for controller_poller_apb: two modelled pads, APB register traffic,
// frame timing, timer polling, mid-frame reset and W1C/DONE collision.
module tb_controller_poller_apb;

  logic PCLK, PRESET, PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic PREADY, PSLVERR, contLATCH, contCLK, IRQ;
  logic [1:0] contREAD;

  logic [7:0] pad0Bits, pad1Bits;
  logic [2:0] padIdx;
  logic prevClkPad;

  int checks, failures;
  int cyc, latchCycles, latchRises, clkRises, busyCycles, overlap, lastRise, prevRise;
  logic prevLatch, prevClkMon;

  controller_poller_apb #(.NUM_CH(2), .NBITS(8), .HALF_DIV(2), .POLL_DEFAULT(0)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .contLATCH(contLATCH), .contCLK(contCLK), .contREAD(contREAD), .IRQ(IRQ)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Pad model: latch loads bit 0, each rising shift clock advances one bit
  assign contREAD = {pad1Bits[padIdx], pad0Bits[padIdx]};
  always @(posedge PCLK) begin
    prevClkPad <= contCLK;
    if (contLATCH) padIdx <= 3'd0;
    else if (contCLK && !prevClkPad) padIdx <= padIdx + 3'd1;
  end

  initial begin
    cyc = 0; latchCycles = 0; latchRises = 0; clkRises = 0; busyCycles = 0;
    overlap = 0; lastRise = 0; prevRise = 0; prevLatch = 1'b0; prevClkMon = 1'b0;
    forever begin
      @(negedge PCLK);
      #1;
      cyc++;
      if (contLATCH) latchCycles++;
      if (contLATCH && !prevLatch) begin
        latchRises++;
        prevRise = lastRise;
        lastRise = cyc;
      end
      if (contCLK && !prevClkMon) clkRises++;
      if (contLATCH && contCLK) overlap++;
      if (PADDR == 8'h04 && PRDATA[0] && !PRESET) busyCycles++;
      prevLatch  = contLATCH;
      prevClkMon = contCLK;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic apbWrite(input logic [7:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h04;
  endtask

  task automatic apbRead(input logic [7:0] a, output logic [31:0] d, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    d = PRDATA;
    err = PSLVERR;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PADDR = 8'h04;
  endtask

  task automatic checkReg(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic err;
    apbRead(a, d, err);
    check(tag, d, exp);
  endtask

  task automatic waitRise(input string tag, input int target);
    int n;
    n = 0;
    while (latchRises < target && n < 300) begin
      @(negedge PCLK);
      n++;
    end
    check(tag, 32'(latchRises >= target), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic err;
    int base, r0, lc0, cr0, bc0, n;
    checks = 0; failures = 0;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h04; PWDATA = 32'd0; pad0Bits = 8'hFF; pad1Bits = 8'hFF;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Reset state
    check("rst_latch", {31'd0, contLATCH}, 32'd0);
    check("rst_clk", {31'd0, contCLK}, 32'd0);
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    check("rst_pready", {31'd0, PREADY}, 32'd1);
    checkReg("rst_ctrl", 8'h00, 32'd0);
    checkReg("rst_status", 8'h04, 32'd0);
    checkReg("rst_period", 8'h08, 32'd0);
    checkReg("rst_changed", 8'h0C, 32'd0);
    checkReg("rst_state0", 8'h10, 32'd0);

    // Test 1: single on-demand frame
    pad0Bits = 8'h7E;
    pad1Bits = 8'hFF;
    lc0 = latchCycles; cr0 = clkRises; bc0 = busyCycles;
    apbWrite(8'h00, 32'h2);
    repeat (40) @(negedge PCLK);
    check("t1_latch_cycles", 32'(latchCycles - lc0), 32'd4);
    check("t1_clk_pulses", 32'(clkRises - cr0), 32'd7);
    check("t1_busy_cycles", 32'(busyCycles - bc0), 32'd33);
    checkReg("t1_state0", 8'h10, 32'h81);
    checkReg("t1_state1", 8'h14, 32'h00);
    checkReg("t1_changed", 8'h0C, 32'h1);
    checkReg("t1_status", 8'h04, 32'h100);
    checkReg("t1_ctrl_poll_reads0", 8'h00, 32'h0);

    // Test 2: interrupt enable and clear
    apbWrite(8'h00, 32'h4);
    @(negedge PCLK);
    check("t2_irq_set", {31'd0, IRQ}, 32'd1);
    apbWrite(8'h0C, 32'h1);
    check("t2_irq_hold", {31'd0, IRQ}, 32'd1);
    @(negedge PCLK);
    check("t2_irq_clear", {31'd0, IRQ}, 32'd0);
    apbWrite(8'h00, 32'h6);
    repeat (40) @(negedge PCLK);
    checkReg("t2_changed_same", 8'h0C, 32'h0);
    checkReg("t2_status", 8'h04, 32'h200);
    check("t2_irq_quiet", {31'd0, IRQ}, 32'd0);

    // Test 3: periodic polling at 100, POLL during a frame is dropped
    r0 = latchRises;
    apbWrite(8'h08, 32'd100);
    apbWrite(8'h00, 32'h5);
    waitRise("t3_first_frame", r0 + 1);
    waitRise("t3_second_frame", r0 + 2);
    check("t3_gap100", 32'(lastRise - prevRise), 32'd100);
    apbWrite(8'h00, 32'h7);
    waitRise("t3_third_frame", r0 + 3);
    check("t3_gap100_after_poll", 32'(lastRise - prevRise), 32'd100);
    checkReg("t3_status_busy", 8'h04, 32'h401);

    // Test 4: period shorter than a frame
    apbWrite(8'h08, 32'd20);
    r0 = latchRises;
    waitRise("t4_frame_a", r0 + 1);
    waitRise("t4_frame_b", r0 + 2);
    check("t4_gap40_a", 32'(lastRise - prevRise), 32'd40);
    waitRise("t4_frame_c", r0 + 3);
    check("t4_gap40_b", 32'(lastRise - prevRise), 32'd40);
    apbWrite(8'h00, 32'h4);
    repeat (50) @(negedge PCLK);
    checkReg("t4_status_en_off", 8'h04, 32'h800);

    // Test 5: reset in the middle of bit 4
    pad1Bits = 8'h00;
    base = clkRises;
    apbWrite(8'h00, 32'h2);
    n = 0;
    while (clkRises < base + 4 && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    check("t5_reached_bit4", 32'(clkRises >= base + 4), 32'd1);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("t5_clk_low", {31'd0, contCLK}, 32'd0);
    check("t5_latch_low", {31'd0, contLATCH}, 32'd0);
    PRESET = 1'b0;
    checkReg("t5_status", 8'h04, 32'h0);
    checkReg("t5_state0", 8'h10, 32'h0);
    checkReg("t5_state1", 8'h14, 32'h0);
    apbWrite(8'h00, 32'h2);
    repeat (40) @(negedge PCLK);
    checkReg("t5_state0_after", 8'h10, 32'h81);
    checkReg("t5_state1_after", 8'h14, 32'hFF);
    checkReg("t5_changed", 8'h0C, 32'h3);
    checkReg("t5_status_after", 8'h04, 32'h100);

    // Test 6: unmapped addresses, read-only STATUS, W1C vs DONE collision
    apbRead(8'h18, d, err);
    check("t6_rd18_data", d, 32'h0);
    check("t6_rd18_err", {31'd0, err}, 32'd1);
    apbRead(8'h40, d, err);
    check("t6_rd40_data", d, 32'h0);
    check("t6_rd40_err", {31'd0, err}, 32'd1);
    apbRead(8'h14, d, err);
    check("t6_rd14_err", {31'd0, err}, 32'd0);
    apbWrite(8'h04, 32'hFFFF_FFFF);
    checkReg("t6_status_ro", 8'h04, 32'h100);
    apbWrite(8'h0C, 32'h1);
    checkReg("t6_changed_pre", 8'h0C, 32'h2);
    pad0Bits = 8'h00;
    apbWrite(8'h00, 32'h2);
    repeat (30) @(negedge PCLK);
    apbWrite(8'h0C, 32'h3);
    repeat (3) @(negedge PCLK);
    checkReg("t6_changed_set_wins", 8'h0C, 32'h1);
    checkReg("t6_state0", 8'h10, 32'hFF);
    checkReg("t6_status", 8'h04, 32'h200);

    check("strobe_overlap", 32'(overlap), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
